mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles waiting on ramready before error.
REQ-002 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port iREN  input  1  instruction fetch request from datapath.
REQ-005 SHALL have port iaddr  input  32  instruction word address.
REQ-006 SHALL have port dREN  input  1  data read request.
REQ-007 SHALL have port dWEN  input  1  data write request.
REQ-008 SHALL have port daddr  input  32  data address.
REQ-009 SHALL have port dstore  input  32  write data.
REQ-010 SHALL have port halt  input  1  datapath halted; blocks new fetches.
REQ-011 SHALL have port ihit / dhit  output  1 each  one-cycle completion pulses.
REQ-012 SHALL have port iload / dload  output  32 each  returned read data.
REQ-013 SHALL have port ramREN / ramWEN  output  1 each  RAM strobes.
REQ-014 SHALL have port ramaddr / ramstore  output  32 each  RAM address / write data.
REQ-015 SHALL have port ramload  input  32  RAM read data; ramready  input  1  RAM access complete.
REQ-016 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, DATA, INSTR, DONE, ERR.
REQ-018 IDLE: if dREN|dWEN go DATA; else if iREN & !halt go INSTR; else stay; data beats instruction when both pending.
REQ-019 On leaving IDLE SHALL latch address, store data and op (write if dWEN, read otherwise; dWEN&dREN = write).
REQ-020 In DATA/INSTR SHALL drive ramaddr/ramstore/ramREN/ramWEN only from latched values; strobes 0 in all other states.
REQ-021 On ramready in DATA/INSTR SHALL capture ramload into dload/iload (reads only) and go DONE.
REQ-022 DONE SHALL last exactly one cycle, assert dhit or ihit for the finished access only, ignore all requests, then go IDLE.
REQ-023 Minimum latency request-to-hit SHALL be 2 cycles when ramready is high the first DATA/INSTR cycle.
REQ-024 Requests deasserted mid-access SHALL NOT abort it; hit still issued.
REQ-025 Wait counter (8 bits min, width fits TIMEOUT) SHALL clear on entry to DATA/INSTR, increment each cycle without ramready; at TIMEOUT go ERR.
REQ-026 ERR SHALL assert err, drive strobes 0, issue no hits, and remain until reset.
REQ-027 halt SHALL not affect an in-flight fetch or any data access.
REQ-028 iload/dload SHALL hold last captured value until next capture.

Reset
REQ-029 RST SHALL asynchronously force state IDLE, counter 0, ihit=dhit=err=0, iload=dload=0, latched regs 0.
REQ-030 RST asserted mid-access SHALL drop RAM strobes immediately with no hit issued.

Configuration
REQ-031 Macro MEM_ARB_STATS_EN defined: SHALL add outputs icount, dcount (16 bits each), incremented per ihit/dhit, saturating at 16'hFFFF, cleared by RST.
REQ-032 Macro undefined: ports icount/dcount SHALL not exist; all other behaviour identical.

Verification
REQ-033 Fetch iaddr=0x40, ramready at 1st INSTR cycle, ramload=0x3C010001 -> ihit 2 cycles after iREN, iload=0x3C010001.
REQ-034 iREN and dREN together, daddr=0x100 -> DATA served first, dhit; then INSTR, ihit; ramaddr 0x100 precedes iaddr.
REQ-035 dWEN=1, daddr=0x80, dstore=0xDEADBEEF, ramready after 3 waits -> ramWEN held 4 cycles with those values, one dhit, dload unchanged.
REQ-036 ramready never asserted, TIMEOUT=4 -> ERR after 4 wait cycles, err=1, strobes 0, no hits thereafter.
REQ-037 halt=1 with iREN=1 -> stays IDLE, ramREN=0; dREN then served normally.
REQ-038 RST pulsed during DATA wait -> strobes 0 same cycle, no dhit, IDLE after release; with MEM_ARB_STATS_EN, counts 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one RAM port between an instruction-fetch requester and a data
//   requester. Data requests win when both are pending. Each access is
//   latched on leaving IDLE and driven to the RAM until ramready. A one-cycle
//   DONE state then pulses the matching hit. An access that waits TIMEOUT
//   cycles without ramready parks the arbiter in a sticky ERR state until
//   reset.
//
//   Optional feature (compile-time macro MEM_ARB_STATS_EN):
//     adds the icount/dcount outputs. These are saturating 16-bit hit counters.
//
// Parameters
//   TIMEOUT   maximum number of cycles to wait on ramready (must be >= 1)
//
// Ports
//   CLK       in   1   clock; all state changes on the rising edge
//   RST       in   1   asynchronous active-high reset
//   iREN      in   1   instruction fetch request
//   iaddr     in  32   instruction address
//   dREN      in   1   data read request
//   dWEN      in   1   data write request (wins over dREN)
//   daddr     in  32   data address
//   dstore    in  32   data write value
//   halt      in   1   blocks new instruction fetches while high
//   ihit      out  1   fetch completion pulse
//   dhit      out  1   data completion pulse
//   iload     out 32   last fetched instruction
//   dload     out 32   last read data
//   ramREN    out  1   RAM read strobe
//   ramWEN    out  1   RAM write strobe
//   ramaddr   out 32   RAM address
//   ramstore  out 32   RAM write data
//   ramload   in  32   RAM read data
//   ramready  in   1   RAM access complete
//   err       out  1   sticky timeout flag
//   icount    out 16   fetch hit count (MEM_ARB_STATS_EN only)
//   dcount    out 16   data hit count  (MEM_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        halt,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
`ifdef MEM_ARB_STATS_EN
  output logic [15:0] icount,
  output logic [15:0] dcount,
`endif
  output logic        err
);

  // The wait counter is at least 8 bits wide and grows if TIMEOUT needs more.
  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW > 8) ? CW_RAW : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    INSTR = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q;
  logic [31:0]   store_q;
  logic          wr_q;     // latched op: 1 = write
  logic          data_q;   // latched requester: 1 = data side
  logic [CW-1:0] cnt_q;
  logic [31:0]   iload_q;
  logic [31:0]   dload_q;

  logic          access;
  logic          take_data;
  logic          take_instr;

  assign access     = (state_q == DATA) || (state_q == INSTR);
  assign take_data  = dREN || dWEN;
  assign take_instr = iREN && !halt;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take_data) begin
          state_d = DATA;
        end else if (take_instr) begin
          state_d = INSTR;
        end
      end
      DATA, INSTR: begin
        // ramready on the last allowed cycle still completes the access.
        if (ramready) begin
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. The strobes are decoded from the state, so an asynchronous
  // reset drops them in the same cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    err      = 1'b0;
    case (state_q)
      DATA, INSTR: begin
        ramREN   = !wr_q;
        ramWEN   = wr_q;
        ramaddr  = addr_q;
        ramstore = store_q;
      end
      DONE: begin
        ihit = !data_q;
        dhit = data_q;
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

  assign iload = iload_q;
  assign dload = dload_q;

  // Request latch, wait counter and read-data capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q  <= 32'd0;
      store_q <= 32'd0;
      wr_q    <= 1'b0;
      data_q  <= 1'b0;
      cnt_q   <= '0;
      iload_q <= 32'd0;
      dload_q <= 32'd0;
    end else begin
      if (state_q == IDLE) begin
        // DATA and INSTR are only entered from IDLE, so the counter is
        // cleared here.
        cnt_q <= '0;
        if (take_data) begin
          addr_q  <= daddr;
          store_q <= dstore;
          wr_q    <= dWEN;
          data_q  <= 1'b1;
        end else if (take_instr) begin
          addr_q  <= iaddr;
          store_q <= 32'd0;
          wr_q    <= 1'b0;
          data_q  <= 1'b0;
        end
      end
      if (access) begin
        if (!ramready) begin
          cnt_q <= cnt_q + 1'b1;
        end else if (!wr_q) begin
          if (data_q) begin
            dload_q <= ramload;
          end else begin
            iload_q <= ramload;
          end
        end
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] icount_q;
  logic [15:0] dcount_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      icount_q <= 16'd0;
      dcount_q <= 16'd0;
    end else begin
      if (ihit && (icount_q != 16'hFFFF)) begin
        icount_q <= icount_q + 16'd1;
      end
      if (dhit && (dcount_q != 16'hFFFF)) begin
        dcount_q <= dcount_q + 16'd1;
      end
    end
  end

  assign icount = icount_q;
  assign dcount = dcount_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with TIMEOUT = 4. Inputs change 1 time unit
//   after a rising edge. Outputs are checked 1 time unit after a rising edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, halt, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] icount, dcount;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .halt     (halt),
    .ihit     (ihit),
    .dhit     (dhit),
    .iload    (iload),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramready (ramready),
`ifdef MEM_ARB_STATS_EN
    .icount   (icount),
    .dcount   (dcount),
`endif
    .err      (err)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; halt = 0; ramready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    tick; tick;
    chk("rst_ihit", {31'd0, ihit}, 0);
    chk("rst_dhit", {31'd0, dhit}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_ren", {31'd0, ramREN}, 0);
    chk("rst_wen", {31'd0, ramWEN}, 0);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    RST = 1'b0;
    tick;
    $display("txn reset done");

    // Instruction fetch with ramready on the first INSTR cycle
    iREN = 1; iaddr = 32'h40;
    tick;
    chk("f_ren", {31'd0, ramREN}, 1);
    chk("f_addr", ramaddr, 32'h40);
    chk("f_ihit_early", {31'd0, ihit}, 0);
    iREN = 0; ramready = 1; ramload = 32'h3C010001;
    tick;
    chk("f_ihit", {31'd0, ihit}, 1);
    chk("f_dhit", {31'd0, dhit}, 0);
    chk("f_iload", iload, 32'h3C010001);
    chk("f_ren_done", {31'd0, ramREN}, 0);
    ramready = 0;
    tick;
    chk("f_ihit_off", {31'd0, ihit}, 0);
    $display("txn fetch 0x40 iload=%h", iload);

    // Simultaneous requests: data first, then instruction
    iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100;
    tick;
    chk("p_daddr", ramaddr, 32'h100);
    chk("p_dren", {31'd0, ramREN}, 1);
    dREN = 0; ramready = 1; ramload = 32'h11112222;
    tick;
    chk("p_dhit", {31'd0, dhit}, 1);
    chk("p_ihit_no", {31'd0, ihit}, 0);
    chk("p_dload", dload, 32'h11112222);
    ramready = 0;
    tick;
    chk("p_idle_ren", {31'd0, ramREN}, 0);
    tick;
    chk("p_iaddr", ramaddr, 32'h44);
    chk("p_iren", {31'd0, ramREN}, 1);
    iREN = 0; ramready = 1; ramload = 32'hAAAA5555;
    tick;
    chk("p_ihit", {31'd0, ihit}, 1);
    chk("p_iload", iload, 32'hAAAA5555);
    chk("p_dload_hold", dload, 32'h11112222);
    ramready = 0;
    tick;
    $display("txn priority dload=%h iload=%h", dload, iload);

    // Write with three wait cycles
    dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF;
    tick;
    chk("w_wen1", {31'd0, ramWEN}, 1);
    chk("w_ren1", {31'd0, ramREN}, 0);
    chk("w_addr1", ramaddr, 32'h80);
    chk("w_store1", ramstore, 32'hDEADBEEF);
    dWEN = 0; daddr = 0; dstore = 0;
    tick;
    chk("w_wen2", {31'd0, ramWEN}, 1);
    chk("w_store2", ramstore, 32'hDEADBEEF);
    tick;
    chk("w_wen3", {31'd0, ramWEN}, 1);
    tick;
    chk("w_wen4", {31'd0, ramWEN}, 1);
    chk("w_addr4", ramaddr, 32'h80);
    chk("w_dhit_early", {31'd0, dhit}, 0);
    ramready = 1; ramload = 32'h12345678;
    tick;
    chk("w_dhit", {31'd0, dhit}, 1);
    chk("w_wen_done", {31'd0, ramWEN}, 0);
    chk("w_dload_hold", dload, 32'h11112222);
    ramready = 0;
    tick;
    chk("w_dhit_off", {31'd0, dhit}, 0);
    $display("txn write 0x80 dload=%h", dload);

    // halt blocks fetch; data still served
    halt = 1; iREN = 1; iaddr = 32'h48;
    tick; tick;
    chk("h_ren", {31'd0, ramREN}, 0);
    chk("h_ihit", {31'd0, ihit}, 0);
    dREN = 1; daddr = 32'h200;
    tick;
    chk("h_dren", {31'd0, ramREN}, 1);
    chk("h_daddr", ramaddr, 32'h200);
    dREN = 0; ramready = 1; ramload = 32'hCAFEF00D;
    tick;
    chk("h_dhit", {31'd0, dhit}, 1);
    chk("h_dload", dload, 32'hCAFEF00D);
    chk("h_iload_hold", iload, 32'hAAAA5555);
    ramready = 0; iREN = 0; halt = 0;
    tick;
`ifdef MEM_ARB_STATS_EN
    chk("s_icount", {16'd0, icount}, 2);
    chk("s_dcount", {16'd0, dcount}, 3);
`endif
    $display("txn halt dload=%h", dload);

    // Reset in the middle of a data wait
    dREN = 1; daddr = 32'h300;
    tick;
    dREN = 0;
    tick;
    chk("r_ren_before", {31'd0, ramREN}, 1);
    RST = 1;
    #1;
    chk("r_ren_async", {31'd0, ramREN}, 0);
    chk("r_dhit", {31'd0, dhit}, 0);
    tick;
    RST = 0;
    tick;
    chk("r_ren_idle", {31'd0, ramREN}, 0);
    chk("r_dhit_idle", {31'd0, dhit}, 0);
    chk("r_dload", dload, 0);
    chk("r_err", {31'd0, err}, 0);
`ifdef MEM_ARB_STATS_EN
    chk("r_icount", {16'd0, icount}, 0);
    chk("r_dcount", {16'd0, dcount}, 0);
`endif
    $display("txn reset mid-access");

    // Timeout: ramready never asserted
    dREN = 1; daddr = 32'h400;
    tick;
    dREN = 0;
    tick; tick; tick;
    chk("t_ren4", {31'd0, ramREN}, 1);
    chk("t_err_early", {31'd0, err}, 0);
    tick;
    chk("t_err", {31'd0, err}, 1);
    chk("t_ren", {31'd0, ramREN}, 0);
    chk("t_wen", {31'd0, ramWEN}, 0);
    iREN = 1; dREN = 1; ramready = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t_err_sticky", {31'd0, err}, 1);
      chk("t_no_ihit", {31'd0, ihit}, 0);
      chk("t_no_dhit", {31'd0, dhit}, 0);
      chk("t_no_ren", {31'd0, ramREN}, 0);
    end
    iREN = 0; dREN = 0; ramready = 0;
    RST = 1;
    #1;
    chk("t_err_clr", {31'd0, err}, 0);
    tick;
    RST = 0;
    tick;
    $display("txn timeout err cleared by reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
